// File: rtl/gf_pkg.sv
// Shared types and helpers for the iterative GF(2^W) multiplier.
// gf_xtime multiplies by x in a field of width w (2..16) and reduces by poly.
package gf_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } gf_mul_state_t;

    // Only the low w bits of v and poly matter; the upper bits are masked off.
    function automatic logic [15:0] gf_xtime(input logic [15:0] v,
                                             input int unsigned w,
                                             input logic [15:0] poly);
        logic [15:0] mask;
        logic [15:0] msb;
        logic [15:0] r;
        mask = (w >= 16) ? '1 : ((16'd1 << w) - 16'd1);
        msb  = v >> (w - 1);
        r    = (v << 1) & mask;
        if (msb[0]) begin
            r = r ^ (poly & mask);
        end
        return r;
    endfunction

endpackage

// File: rtl/gf_digit_step.sv
// Combinational datapath: DIGIT Horner steps, consuming b_i MSB-first.
// acc_o = xtime(...xtime(acc_i) ^ b_i[DIGIT-1]·a_i ...) ^ b_i[0]·a_i
module gf_digit_step
    import gf_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter logic [15:0] POLY  = 16'(AES_POLY),
    parameter int unsigned DIGIT = 1
) (
    input  logic [W-1:0]     acc_i,
    input  logic [W-1:0]     a_i,
    input  logic [DIGIT-1:0] b_i,
    output logic [W-1:0]     acc_o
);

    always_comb begin
        logic [W-1:0]     acc_v;
        logic [DIGIT-1:0] bits_v;
        logic [15:0]      x_v;
        acc_v  = acc_i;
        bits_v = b_i;
        x_v    = '0;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            x_v    = gf_xtime(16'(acc_v), W, POLY);
            acc_v  = x_v[W-1:0] ^ (bits_v[DIGIT-1] ? a_i : '0);
            bits_v = bits_v << 1;
        end
        acc_o = acc_v;
    end

endmodule

// File: rtl/gf_mul_iter.sv
// Iterative GF(2^W) multiplier p = a*b mod (x^W + POLY), DIGIT bits of b per cycle.
// Fixed N = W/DIGIT BUSY cycles regardless of operand values (constant time).
module gf_mul_iter
    import gf_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter logic [15:0] POLY  = 16'(AES_POLY),
    parameter int unsigned DIGIT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] p
);

    if (W < 2 || W > 16 || DIGIT == 0 || (W % DIGIT) != 0) begin : g_bad_param
        $error("gf_mul_iter: W must be 2..16 and DIGIT must divide W");
    end

    localparam int unsigned N  = W / DIGIT;
    localparam int unsigned CW = $clog2(N + 1);

    gf_mul_state_t state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  p_q, p_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ov_q, ov_d;
    logic [W-1:0]  step_acc;

    gf_digit_step #(
        .W     (W),
        .POLY  (POLY),
        .DIGIT (DIGIT)
    ) u_step (
        .acc_i (acc_q),
        .a_i   (a_q),
        .b_i   (b_q[W-1 -: DIGIT]),
        .acc_o (step_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        ov_d    = ov_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = step_acc;
                b_d   = b_q << DIGIT;
                cnt_d = cnt_q + 1'b1;
                // p is loaded straight from the step output so DONE presents it at once.
                if (cnt_q == CW'(N - 1)) begin
                    p_d     = step_acc;
                    ov_d    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = ov_q;
    assign p         = p_q;

endmodule

// File: tb/tb_gf_mul_iter.sv
// Bench for gf_mul_iter: three builds (W8/D1, W8/D4, W4/D2) checked against a
// carry-less-multiply-then-long-division reference model.
module tb_gf_mul_iter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a_s = '0;
    logic [7:0] b_s = '0;
    logic [2:0] vld = '0;
    logic [2:0] ordy = '0;
    logic [2:0] ir;
    logic [2:0] ov;
    logic [7:0] p1, p2;
    logic [3:0] p3;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    gf_mul_iter #(.W(8), .POLY(16'h001B), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(ir[0]),
        .a(a_s), .b(b_s), .out_valid(ov[0]), .out_ready(ordy[0]), .p(p1));

    gf_mul_iter #(.W(8), .POLY(16'h001B), .DIGIT(4)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(ir[1]),
        .a(a_s), .b(b_s), .out_valid(ov[1]), .out_ready(ordy[1]), .p(p2));

    gf_mul_iter #(.W(4), .POLY(16'h0003), .DIGIT(2)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(ir[2]),
        .a(a_s[3:0]), .b(b_s[3:0]), .out_valid(ov[2]), .out_ready(ordy[2]), .p(p3));

    // Schoolbook polynomial product, then reduce from the top bit down.
    function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y,
                                           input int w, input logic [15:0] poly);
        logic [31:0] prod;
        logic [31:0] m;
        logic [31:0] xm;
        xm   = 32'(x) & ((32'd1 << w) - 32'd1);
        m    = (32'd1 << w) | (32'(poly) & ((32'd1 << w) - 32'd1));
        prod = '0;
        for (int i = 0; i < w; i++)
            if (y[i]) prod = prod ^ (xm << i);
        for (int i = 2 * w - 2; i >= w; i--)
            if (prod[i]) prod = prod ^ (m << (i - w));
        return prod[7:0];
    endfunction

    function automatic int lat_of(input int sel);
        return (sel == 0) ? 8 : 2;
    endfunction

    function automatic logic [7:0] pout(input int sel);
        case (sel)
            0:       return p1;
            1:       return p2;
            default: return {4'b0, p3};
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input int sel, input logic [7:0] x, input logic [7:0] y,
                          input bit consume, output logic [7:0] res, output int lat);
        int guard;
        guard = 0;
        while (!ir[sel] && guard < 40) begin
            @(posedge clk); #1; guard++;
        end
        a_s = x; b_s = y; vld[sel] = 1'b1;
        @(posedge clk); #1;
        vld[sel] = 1'b0;
        lat = 0;
        while (!ov[sel] && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        res = pout(sel);
        if (consume) begin
            ordy[sel] = 1'b1;
            @(posedge clk); #1;
            ordy[sel] = 1'b0;
        end
    endtask

    task automatic op_exp(input int sel, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] exp, input string tag);
        logic [7:0] res;
        int lat;
        run_op(sel, x, y, 1'b1, res, lat);
        check({tag, "_p"}, 16'(res), 16'(exp));
        check({tag, "_lat"}, 16'(lat), 16'(lat_of(sel)));
    endtask

    task automatic op_rand(input int sel, input string tag);
        logic [7:0] x, y, e;
        x = 8'($urandom); y = 8'($urandom);
        if (sel == 2) begin x = x & 8'h0F; y = y & 8'h0F; end
        e = (sel == 2) ? ref_mul(x, y, 4, 16'h3) : ref_mul(x, y, 8, 16'h1B);
        op_exp(sel, x, y, e, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] res, x;
        logic [7:0] q[$];
        int lat, last_acc;
        bit prev_ready;

        // Reset state
        #12;
        check("rst_ready", 16'(ir), 16'(3'b111));
        check("rst_valid", 16'(ov), 16'(3'b000));
        check("rst_p", {p1, p2}, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 0x57 * 0x83 with 20 cycles of backpressure and an ignored in_valid
        run_op(0, 8'h57, 8'h83, 1'b0, res, lat);
        check("c1_p", 16'(res), 16'h00C1);
        check("c1_lat", 16'(lat), 16'd8);
        a_s = 8'h11; b_s = 8'h22; vld[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            check("stall", {6'b0, ov[0], ir[0], p1}, {6'b0, 1'b1, 1'b0, 8'hC1});
        end
        vld[0] = 1'b0; ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        check("release", {6'b0, ir[0], ov[0], p1}, {6'b0, 1'b1, 1'b0, 8'hC1});

        // Directed vectors
        op_exp(0, 8'h57, 8'h13, 8'hFE, "fe");
        op_exp(0, 8'hD4, 8'h03, 8'h67, "x3");
        op_exp(0, 8'hFF, 8'h00, 8'h00, "bzero");
        op_exp(0, 8'h00, 8'hA5, 8'h00, "azero");
        for (int k = 0; k < 4; k++) begin
            x = 8'($urandom);
            op_exp(0, x, 8'h01, x, "bone");
        end
        op_exp(1, 8'h57, 8'h83, 8'hC1, "d4_c1");
        op_exp(2, 8'h09, 8'h0B, 8'h0C, "w4_c");

        // Random operands on every build
        for (int k = 0; k < 12; k++) op_rand(0, "r_d1");
        for (int k = 0; k < 25; k++) op_rand(1, "r_d4");
        for (int k = 0; k < 25; k++) op_rand(2, "r_w4");

        // Asynchronous reset in BUSY cycle 4 discards the operation
        while (!ir[0]) begin @(posedge clk); #1; end
        a_s = 8'h57; b_s = 8'h83; vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst", {6'b0, ov[0], ir[0], p1}, {6'b0, 1'b0, 1'b1, 8'h00});
        check("mid_rst_p", {p2, 4'b0, p3}, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        op_exp(0, 8'h02, 8'h87, 8'h15, "post_rst");

        // Back-to-back accepts with out_ready held high: N+2 spacing
        ordy[0] = 1'b1;
        a_s = 8'($urandom); b_s = 8'($urandom);
        vld[0] = 1'b1;
        prev_ready = ir[0];
        last_acc = -1;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk); #1;
            if (prev_ready) begin
                q.push_back(ref_mul(a_s, b_s, 8, 16'h1B));
                if (last_acc >= 0) check("spacing", 16'(cyc - last_acc), 16'd10);
                last_acc = cyc;
                a_s = 8'($urandom); b_s = 8'($urandom);
            end
            if (ov[0]) begin
                check("tput_q", 16'(q.size()), 16'd1);
                if (q.size() > 0) check("tput_p", 16'(p1), 16'(q.pop_front()));
            end
            prev_ready = ir[0];
        end
        vld[0] = 1'b0;
        repeat (12) @(posedge clk);
        #1 ordy[0] = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
